// File: rtl/bus_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// bus_xfer_ctrl
//
// Register-transfer sequencer for the datapath's 32-bit internal bus.
// Transfer commands {src, dst, len} arrive over a valid/ready handshake and
// wait in a small FIFO. They run one at a time. The source code is decoded to
// a one-hot bus-drive enable (out_en). The destination code is decoded to a
// one-hot register-load enable (in_en). in_en is asserted only in the last
// cycle of each transfer.
//
// Code map (src and dst share it; bit n of out_en/in_en is code n):
//   0-15 R0-R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 INPORT,
//   23 C, 24-31 illegal (decode to all-zero enables).
//
// Optional feature: define BUS_XFER_CODECHK_EN to enable illegal-code
// checking. With it, an illegal command completes its handshake but is
// dropped, and the sticky err flag is set. Without it, illegal commands
// execute with zero enables on the illegal side, and err is tied to 0.
//
// Ports:
//   clock      in   rising-edge clock
//   clear      in   asynchronous active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  FIFO can accept (== !full)
//   cmd_src    in   [4:0] source code
//   cmd_dst    in   [4:0] destination code
//   cmd_len    in   [1:0] extra hold cycles (transfer lasts len+1 cycles)
//   out_en     out  [NREG-1:0] one-hot bus-drive enable
//   in_en      out  [NREG-1:0] one-hot register-load enable
//   busy       out  transfer in progress or FIFO non-empty
//   err        out  sticky illegal-code flag
//   err_clr    in   synchronous clear of err
// ---------------------------------------------------------------------------
module bus_xfer_ctrl #(
  parameter int DEPTH = 4,
  parameter int NREG  = 24
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [4:0]      cmd_src,
  input  logic [4:0]      cmd_dst,
  input  logic [1:0]      cmd_len,
  output logic [NREG-1:0] out_en,
  output logic [NREG-1:0] in_en,
  output logic            busy,
  output logic            err,
  input  logic            err_clr
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [4:0] src;
    logic [4:0] dst;
    logic [1:0] len;
  } cmd_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // Decode a register code to a one-hot enable. Codes at or above NREG
  // match no bit, so they yield zero.
  function automatic logic [NREG-1:0] onehot(input logic [4:0] code);
    logic [NREG-1:0] vec;
    for (int i = 0; i < NREG; i++) begin
      vec[i] = (int'(code) == i);
    end
    return vec;
  endfunction

  // -------------------------------------------------------------------------
  // Command FIFO
  // -------------------------------------------------------------------------
  cmd_t        mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        empty, full;
  logic        push, enq, pop;
  cmd_t        head;
  state_t      state_q;
  logic [1:0]  cnt_q;
  logic [4:0]  cur_dst_q;
  logic [NREG-1:0] out_en_q, in_en_q;

  // The pointers carry one extra wrap bit. Equal pointers mean empty. Pointers
  // that differ only in the wrap bit mean full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // full is taken from the registered pointers. A pop on the same edge
  // therefore cannot make room for the push on that edge.
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  // Pop when idle with work queued, or when the current transfer is in its
  // final cycle. The second case gives back-to-back transfers with no gap.
  assign pop = !empty && ((state_q == IDLE) || (cnt_q == 2'd0));

`ifdef BUS_XFER_CODECHK_EN
  logic code_ok;
  logic err_q;

  assign code_ok = (int'(cmd_src) < NREG) && (int'(cmd_dst) < NREG);
  assign enq     = push && code_ok;

  // A new error has priority over err_clr on the same edge.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      err_q <= 1'b0;
    end else if (push && !code_ok) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  logic unused_err_clr;

  assign enq            = push;
  assign err            = 1'b0;
  assign unused_err_clr = err_clr;
`endif

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // NOTE: the storage array has no reset. Stale entries are never read,
  // because the pointers (which are reset) gate every access.
  always_ff @(posedge clock) begin
    if (enq) mem_q[wr_ptr_q[AW-1:0]] <= cmd_t'{src: cmd_src, dst: cmd_dst, len: cmd_len};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block order.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Transfer sequencer. The enables are registered, so cmd_* has no
  // combinational path to the bus-control outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cur_dst_q <= '0;
      out_en_q  <= '0;
      in_en_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q   <= XFER;
            cnt_q     <= head.len;
            cur_dst_q <= head.dst;
            out_en_q  <= onehot(head.src);
            in_en_q   <= (head.len == 2'd0) ? onehot(head.dst) : '0;
          end else begin
            out_en_q <= '0;
            in_en_q  <= '0;
          end
        end
        XFER: begin
          if (cnt_q != 2'd0) begin
            // Hold the source on the bus. Assert the load enable in the
            // cycle where the count reaches zero.
            cnt_q   <= cnt_q - 2'd1;
            in_en_q <= (cnt_q == 2'd1) ? onehot(cur_dst_q) : '0;
          end else if (pop) begin
            cnt_q     <= head.len;
            cur_dst_q <= head.dst;
            out_en_q  <= onehot(head.src);
            in_en_q   <= (head.len == 2'd0) ? onehot(head.dst) : '0;
          end else begin
            state_q  <= IDLE;
            out_en_q <= '0;
            in_en_q  <= '0;
          end
        end
        default: begin
          state_q  <= IDLE;
          out_en_q <= '0;
          in_en_q  <= '0;
        end
      endcase
    end
  end

  assign out_en = out_en_q;
  assign in_en  = in_en_q;
  assign busy   = (state_q == XFER) || !empty;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bus_xfer_ctrl
//
// Self-checking bench for bus_xfer_ctrl. An accepted command is pushed onto a
// scoreboard queue. A transfer model pops entries from the queue and produces
// the expected out_en/in_en/busy/cmd_ready/err. A monitor compares these with
// the DUT outputs on every falling edge. Directed sequences add fixed
// expectations for the main scenarios. Define BUS_XFER_CODECHK_EN to match an
// RTL build that has code checking enabled.
// ---------------------------------------------------------------------------
module tb_bus_xfer_ctrl;
  localparam int DEPTH = 4;
  localparam int NREG  = 24;

  logic            clock     = 1'b0;
  logic            clear     = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            err_clr   = 1'b0;
  logic [4:0]      cmd_src   = '0;
  logic [4:0]      cmd_dst   = '0;
  logic [1:0]      cmd_len   = '0;
  logic            cmd_ready;
  logic            busy;
  logic            err;
  logic [NREG-1:0] out_en;
  logic [NREG-1:0] in_en;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [4:0] src;
    logic [4:0] dst;
    logic [1:0] len;
  } xfer_t;

  xfer_t      sb_q[$];
  bit         m_xfer = 1'b0;
  logic [4:0] m_src  = '0;
  logic [4:0] m_dst  = '0;
  logic [1:0] m_cnt  = '0;
  bit         m_err  = 1'b0;
  bit         m_acc  = 1'b0;
  bit         mon_en = 1'b0;

  bus_xfer_ctrl #(.DEPTH(DEPTH), .NREG(NREG)) dut (
    .clock     (clock),
    .clear     (clear),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_len   (cmd_len),
    .out_en    (out_en),
    .in_en     (in_en),
    .busy      (busy),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [NREG-1:0] code_bit(input logic [4:0] c);
    logic [NREG-1:0] one;
    one = 1;
    return (c < 5'd24) ? (one << c) : '0;
  endfunction

  // Reference model, advanced on each rising edge and reset asynchronously.
  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      sb_q.delete();
      m_xfer = 1'b0;
      m_cnt  = '0;
      m_err  = 1'b0;
      m_acc  = 1'b0;
    end else begin
      bit    was_full;
      bit    bad;
      xfer_t c;
      was_full = (sb_q.size() == DEPTH);
      m_acc    = cmd_valid && !was_full;
      bad      = (cmd_src > 5'd23) || (cmd_dst > 5'd23);
      if (m_xfer && m_cnt != 2'd0) begin
        m_cnt = m_cnt - 2'd1;
      end else if (sb_q.size() > 0) begin
        c      = sb_q.pop_front();
        m_xfer = 1'b1;
        m_src  = c.src;
        m_dst  = c.dst;
        m_cnt  = c.len;
      end else begin
        m_xfer = 1'b0;
      end
`ifdef BUS_XFER_CODECHK_EN
      if (m_acc && bad) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      if (m_acc && !bad) sb_q.push_back(xfer_t'{src: cmd_src, dst: cmd_dst, len: cmd_len});
`else
      if (bad) m_err = 1'b0;
      if (m_acc) sb_q.push_back(xfer_t'{src: cmd_src, dst: cmd_dst, len: cmd_len});
`endif
    end
  end

  // Cycle monitor: compares the DUT outputs with the model on every falling
  // edge.
  always @(negedge clock) begin
    if (clear && mon_en) begin
      check("out_en",    32'(out_en),    32'(m_xfer ? code_bit(m_src) : '0));
      check("in_en",     32'(in_en),     32'((m_xfer && m_cnt == 2'd0) ? code_bit(m_dst) : '0));
      check("busy",      32'(busy),      32'(m_xfer || sb_q.size() > 0));
      check("cmd_ready", 32'(cmd_ready), 32'(sb_q.size() < DEPTH));
      check("err",       32'(err),       32'(m_err));
    end
  end

  // Drive one command and hold cmd_valid until it is accepted. Returns 1 ns
  // after the accepting edge with cmd_valid low. Calling it again right away
  // keeps cmd_valid high over consecutive edges.
  task automatic push_cmd(input logic [4:0] s, input logic [4:0] d, input logic [1:0] l);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_src   = s;
    cmd_dst   = d;
    cmd_len   = l;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!m_acc && n < 50);
    check("push_accepted", 32'(m_acc), 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (busy && n < budget);
    check("wait_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state while clear is low.
    #12;
    check("rst_out_en",    32'(out_en),    32'd0);
    check("rst_in_en",     32'(in_en),     32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_err",       32'(err),       32'd0);
    @(posedge clock);
    #1;
    clear  = 1'b1;
    mon_en = 1'b1;

    // Single PC -> MDR transfer, len 0.
    push_cmd(5'd20, 5'd21, 2'd0);
    @(posedge clock); #1;
    check("t1_out_en", 32'(out_en), 32'h100000);
    check("t1_in_en",  32'(in_en),  32'h200000);
    @(posedge clock); #1;
    check("t1_out_done", 32'(out_en), 32'd0);
    check("t1_in_done",  32'(in_en),  32'd0);
    check("t1_busy",     32'(busy),   32'd0);

    // R3 -> HI (len 2), then LO -> R0 back-to-back.
    push_cmd(5'd3, 5'd16, 2'd2);
    push_cmd(5'd17, 5'd0, 2'd0);
    check("t2_c1_out", 32'(out_en), 32'h000008);
    check("t2_c1_in",  32'(in_en),  32'h000000);
    @(posedge clock); #1;
    check("t2_c2_out", 32'(out_en), 32'h000008);
    check("t2_c2_in",  32'(in_en),  32'h000000);
    @(posedge clock); #1;
    check("t2_c3_out", 32'(out_en), 32'h000008);
    check("t2_c3_in",  32'(in_en),  32'h010000);
    @(posedge clock); #1;
    check("t2_b_out", 32'(out_en), 32'h020000);
    check("t2_b_in",  32'(in_en),  32'h000001);
    wait_idle(20);

    // Hold cmd_valid high with len 3 commands and fill the FIFO.
    for (int i = 0; i < 7; i++) begin
      push_cmd(5'(i), 5'(i + 8), 2'd3);
      if (i == 4) check("t3_full_after5", 32'(cmd_ready), 32'd0);
    end
    wait_idle(100);

    // Reset in the middle of a transfer discards the queue.
    push_cmd(5'd5, 5'd6, 2'd3);
    push_cmd(5'd7, 5'd8, 2'd1);
    push_cmd(5'd9, 5'd10, 2'd0);
    check("t4_pre_out", 32'(out_en), 32'h000020);
    #1;
    clear = 1'b0;
    #1;
    check("t4_rst_out",   32'(out_en),    32'd0);
    check("t4_rst_in",    32'(in_en),     32'd0);
    check("t4_rst_busy",  32'(busy),      32'd0);
    check("t4_rst_ready", 32'(cmd_ready), 32'd1);
    @(posedge clock); #1;
    clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("t4_discarded", 32'(busy), 32'd0);
    end

    // Illegal source code 25.
    push_cmd(5'd25, 5'd2, 2'd0);
`ifdef BUS_XFER_CODECHK_EN
    check("t5_err_set",  32'(err),  32'd1);
    check("t5_busy",     32'(busy), 32'd0);
    @(posedge clock); #1;
    check("t5_no_out", 32'(out_en), 32'd0);
    check("t5_no_in",  32'(in_en),  32'd0);
    err_clr = 1'b1;
    @(posedge clock); #1;
    err_clr = 1'b0;
    check("t5_err_clr", 32'(err), 32'd0);
    // A new error on the same edge as err_clr leaves err set.
    err_clr = 1'b1;
    push_cmd(5'd30, 5'd1, 2'd0);
    err_clr = 1'b0;
    check("t5_set_wins", 32'(err), 32'd1);
`else
    check("t6_busy", 32'(busy), 32'd1);
    @(posedge clock); #1;
    check("t6_out", 32'(out_en), 32'd0);
    check("t6_in",  32'(in_en),  32'h000004);
    check("t6_err", 32'(err),    32'd0);
    err_clr = 1'b1;
    @(posedge clock); #1;
    err_clr = 1'b0;
    check("t6_idle", 32'(busy), 32'd0);
`endif
    wait_idle(20);

    // Random commands with a mix of legal and illegal codes, checked by the
    // monitor.
    for (int i = 0; i < 20; i++) begin
      push_cmd(5'($urandom_range(0, 26)), 5'($urandom_range(0, 26)), 2'($urandom_range(0, 3)));
    end
    wait_idle(200);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
